fp_result_collector: RTL and testbench

Receiving end of the floating-point multiplier's result stream in the Kalman filter datapath. Accepts a batch of a programmed number of 32-bit results from the multiplier core's result AXI-stream master with a proper tvalid/tready handshake. Buffers the results in a small FIFO and signals batch completion, so downstream matrix-update logic can pop results at its own pace.

---
 rtl/kf_pkg.sv | 12 +
 rtl/kf_sync_fifo.sv | 63 ++++++
 rtl/fp_result_collector.sv | 104 ++++++++++
 tb/tb_fp_result_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Shared constants and types for the Kalman filter result path.
// Collector FSM encoding lives here so the bench and other blocks agree on it.
package kf_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } collect_state_e;

endpackage

// File: rtl/kf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy count.
// dout reads zero whenever the FIFO is empty.
module kf_sync_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_push  = push & ~w_full;
    assign w_pop   = pop & ~w_empty;

    // Storage is not reset: the level counter alone decides what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

// File: rtl/fp_result_collector.sv
// Collects a programmed-length batch of multiplier results over AXI-stream
// into a small FWFT FIFO and pulses done once the last word is accepted.
module fp_result_collector #(
    parameter  int DATA_W  = kf_pkg::DATA_W,
    parameter  int DEPTH   = 4,
    parameter  int COUNT_W = 8,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] expected,
    input  logic               s_axis_result_tvalid,
    input  logic [DATA_W-1:0]  s_axis_result_tdata,
    output logic               s_axis_result_tready,
    input  logic               pop,
    output logic [DATA_W-1:0]  dout,
    output logic               empty,
    output logic [LVL_W-1:0]   level,
    output logic               busy,
    output logic               done,
    output logic               stray
);

    import kf_pkg::*;

    collect_state_e     r_state;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_target;
    logic               r_done;
    logic               r_stray;

    logic [LVL_W-1:0]   w_level;
    logic               w_tready;
    logic               w_hs;
    logic               w_last;

    // tready depends only on registered state, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_tready = (r_state == ST_COLLECT) && (w_level < LVL_W'(DEPTH));
    assign w_hs     = s_axis_result_tvalid & w_tready;
    assign w_last   = w_hs && (r_count == r_target - COUNT_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
            r_stray  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_stray <= 1'b0;
                        if (expected != '0) begin
                            r_state  <= ST_COLLECT;
                            r_count  <= '0;
                            r_target <= expected;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                    // A word offered while idle is dropped but remembered.
                    if (s_axis_result_tvalid) begin
                        r_stray <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_hs) begin
                        r_count <= r_count + COUNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    kf_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (w_hs),
        .pop    (pop),
        .din    (s_axis_result_tdata),
        .dout   (dout),
        .level  (w_level)
    );

    assign s_axis_result_tready = w_tready;
    assign level                = w_level;
    assign empty                = (w_level == '0);
    assign busy                 = (r_state == ST_COLLECT);
    assign done                 = r_done;
    assign stray                = r_stray;

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector: expected words go into a queue at
// stimulus time and a negedge monitor compares them as the consumer pops.
module tb_fp_result_collector;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int COUNT_W = 8;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic               clock;
    logic               reset;
    logic               start;
    logic [COUNT_W-1:0] expected;
    logic               tvalid;
    logic [DATA_W-1:0]  tdata;
    logic               tready;
    logic               pop;
    logic [DATA_W-1:0]  dout;
    logic               empty;
    logic [LVL_W-1:0]   level;
    logic               busy;
    logic               done;
    logic               stray;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] bp_words [6];

    fp_result_collector #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .expected             (expected),
        .s_axis_result_tvalid (tvalid),
        .s_axis_result_tdata  (tdata),
        .s_axis_result_tready (tready),
        .pop                  (pop),
        .dout                 (dout),
        .empty                (empty),
        .level                (level),
        .busy                 (busy),
        .done                 (done),
        .stray                (stray)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        pop = 1'b1;
        repeat (n) tick();
        pop = 1'b0;
    endtask

    // Scoreboard monitor: a pop of a non-empty FIFO consumes dout at the next edge.
    always @(negedge clock) begin
        if (!reset && pop && !empty) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%08h expected no word", dout);
            end else begin
                if (dout !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL pop_data: got 0x%08h expected 0x%08h", dout, exp_q[0]);
                end else begin
                    $display("ok   pop_data: 0x%08h", dout);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; expected = '0;
        tvalid = 1'b0; tdata = '0; pop = 1'b0;
        bp_words[0] = 32'h41000001; bp_words[1] = 32'h41000002;
        bp_words[2] = 32'h41000003; bp_words[3] = 32'h41000004;
        bp_words[4] = 32'h41000005; bp_words[5] = 32'h41000006;
        tick(); tick();
        reset = 1'b0;
        check("rst_tready", 32'(tready), 0);
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);
        check("rst_stray",  32'(stray),  0);
        check("rst_empty",  32'(empty),  1);
        check("rst_level",  32'(level),  0);
        check("rst_dout",   dout,        0);

        // Basic batch of three
        start = 1'b1; expected = 8'd3; tick(); start = 1'b0;
        check("basic_busy",   32'(busy),   1);
        check("basic_tready", 32'(tready), 1);
        tvalid = 1'b1; tdata = 32'h3F800000; exp_q.push_back(32'h3F800000); tick();
        check("basic_lvl1",  32'(level), 1);
        check("basic_dout1", dout, 32'h3F800000);
        check("basic_done0", 32'(done), 0);
        tdata = 32'h40000000; exp_q.push_back(32'h40000000); tick();
        tdata = 32'h40400000; exp_q.push_back(32'h40400000); tick();
        tvalid = 1'b0;
        check("basic_done",   32'(done),   1);
        check("basic_idle",   32'(busy),   0);
        check("basic_trdy0",  32'(tready), 0);
        check("basic_lvl3",   32'(level),  3);
        tick();
        check("basic_done_1cyc", 32'(done), 0);
        drain(3);
        check("basic_empty", 32'(empty), 1);

        // Backpressure: six words through a four-deep FIFO
        start = 1'b1; expected = 8'd6; tick(); start = 1'b0;
        tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdata = bp_words[i]; exp_q.push_back(bp_words[i]); tick();
        end
        check("bp_full_tready", 32'(tready), 0);
        check("bp_full_level",  32'(level),  4);
        tdata = bp_words[4]; exp_q.push_back(bp_words[4]); tick();
        check("bp_stall_level", 32'(level), 4);
        check("bp_stall_busy",  32'(busy),  1);
        pop = 1'b1; tick(); pop = 1'b0;
        check("bp_pop_level", 32'(level),  3);
        check("bp_reopen",    32'(tready), 1);
        tick();
        check("bp_push5_level", 32'(level), 4);
        tdata = bp_words[5]; exp_q.push_back(bp_words[5]);
        pop = 1'b1; tick(); pop = 1'b0;
        tick();
        tvalid = 1'b0;
        check("bp_done",  32'(done),  1);
        check("bp_level", 32'(level), 4);
        drain(4);
        check("bp_empty", 32'(empty), 1);

        // Simultaneous pop and push at level 2, then pop while empty
        start = 1'b1; expected = 8'd3; tick(); start = 1'b0;
        tvalid = 1'b1;
        tdata = 32'hA0000001; exp_q.push_back(32'hA0000001); tick();
        tdata = 32'hA0000002; exp_q.push_back(32'hA0000002); tick();
        check("sim_level2", 32'(level), 2);
        tdata = 32'hA0000003; exp_q.push_back(32'hA0000003);
        pop = 1'b1; tick(); pop = 1'b0; tvalid = 1'b0;
        check("sim_level_hold", 32'(level), 2);
        check("sim_done",       32'(done),  1);
        drain(2);
        pop = 1'b1; tick(); pop = 1'b0;
        check("popempty_level", 32'(level), 0);
        check("popempty_dout",  dout,       0);
        check("popempty_empty", 32'(empty), 1);

        // Zero-length batch
        start = 1'b1; expected = 8'd0; tick(); start = 1'b0;
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        tick();
        check("zero_done_1cyc", 32'(done), 0);
        check("zero_busy2",     32'(busy), 0);

        // Stray word in IDLE, cleared by the next start
        tvalid = 1'b1; tdata = 32'hDEADBEEF; tick(); tvalid = 1'b0;
        check("stray_set",    32'(stray),  1);
        check("stray_tready", 32'(tready), 0);
        check("stray_level",  32'(level),  0);
        start = 1'b1; expected = 8'd1; tick(); start = 1'b0;
        check("stray_clear", 32'(stray), 0);
        tvalid = 1'b1; tdata = 32'hC0A00000; exp_q.push_back(32'hC0A00000); tick(); tvalid = 1'b0;
        check("stray_batch_done", 32'(done), 1);
        drain(1);

        // Reset in the middle of a batch
        start = 1'b1; expected = 8'd5; tick(); start = 1'b0;
        tvalid = 1'b1;
        tdata = 32'h11111111; tick();
        tdata = 32'h22222222; tick();
        tvalid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_empty", 32'(empty),  1);
        check("mid_rst_busy",  32'(busy),   0);
        check("mid_rst_done",  32'(done),   0);
        check("mid_rst_level", 32'(level),  0);
        check("mid_rst_trdy",  32'(tready), 0);
        tick();
        check("mid_rst_nodone", 32'(done), 0);
        start = 1'b1; expected = 8'd1; tick(); start = 1'b0;
        tvalid = 1'b1; tdata = 32'h3F000000; exp_q.push_back(32'h3F000000); tick(); tvalid = 1'b0;
        check("post_rst_done", 32'(done), 1);
        drain(1);

        // Wrap-around: ten push/pop pairs
        start = 1'b1; expected = 8'd10; tick(); start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tvalid = 1'b1; tdata = 32'(i); exp_q.push_back(32'(i));
            pop = (i > 1);
            tick();
        end
        tvalid = 1'b0;
        check("wrap_done",  32'(done),  1);
        check("wrap_level", 32'(level), 1);
        pop = 1'b1; tick(); pop = 1'b0;
        check("wrap_empty", 32'(empty), 1);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
